// File: rtl/booth_mul_8bit.sv
// Sequential radix-2 Booth multiplier, 8x8 signed -> 16-bit signed.
// One add/sub-and-shift per clock through an 8-bit carry-lookahead adder.

module cla_8bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  function automatic logic [3:0] lac4(
    input logic [3:0] gi,
    input logic [3:0] pi,
    input logic       ci
  );
    logic [3:0] co;
    co[0] = gi[0] | (pi[0] & ci);
    co[1] = gi[1] | (pi[1] & gi[0])
          | (pi[1] & pi[0] & ci);
    co[2] = gi[2] | (pi[2] & gi[1])
          | (pi[2] & pi[1] & gi[0])
          | (pi[2] & pi[1] & pi[0] & ci);
    co[3] = gi[3] | (pi[3] & gi[2])
          | (pi[3] & pi[2] & gi[1])
          | (pi[3] & pi[2] & pi[1] & gi[0])
          | (&pi & ci);
    return co;
  endfunction

  always_comb begin
    g      = a_i & b_i;
    p      = a_i ^ b_i;
    c[0]   = cin_i;
    c[4:1] = lac4(g[3:0], p[3:0], cin_i);
    c[8:5] = lac4(g[7:4], p[7:4], c[4]);
    sum_o  = p ^ c[7:0];
    cout_o = c[8];
  end

endmodule

module booth_mul_8bit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q1_q, q1_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic             do_add;
  logic             do_sub;
  logic [WIDTH-1:0] opb;
  logic             opb8;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [WIDTH:0]   a_new;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] q_sh;
  logic             accept;

  assign do_add = ~q_q[0] & q1_q;
  assign do_sub = q_q[0] & ~q1_q;
  assign opb    = do_sub ? ~m_q : m_q;
  assign opb8   = do_sub ? ~m_q[WIDTH-1] : m_q[WIDTH-1];

  cla_8bit u_cla (
    .a_i    (a_q[WIDTH-1:0]),
    .b_i    (opb),
    .cin_i  (do_sub),
    .sum_o  (sum),
    .cout_o (cout)
  );

  // Bit 8 is the sign-extended top of a 9-bit add so M=-128 never overflows.
  always_comb begin
    a_new = a_q;
    unique case (1'b1)
      do_add, do_sub: a_new = {a_q[WIDTH] ^ opb8 ^ cout, sum};
      default:        a_new = a_q;
    endcase
    a_sh = {a_new[WIDTH], a_new[WIDTH:1]};
    q_sh = {a_new[0], q_q[WIDTH-1:1]};
  end

  // A start held into DONE is taken on the edge that would return to IDLE.
  assign accept = start &
    ((state_q == S_IDLE) | (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = 4'd8;
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        a_d   = a_sh;
        q_d   = q_sh;
        q1_d  = q_q[0];
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          prod_d  = {a_sh[WIDTH-1:0], q_sh};
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = prod_q;

endmodule
